// File: rtl/delay_tap_estimator.sv
// Lag estimator: sweeps candidate lags 0..31, sums |dly - ref[k]| over 2^WIN_LOG2 samples, reports the minimising lag.
// Optional best-error output port enabled by defining DELAY_TAP_EST_ERR_OUT_EN.
module delay_tap_estimator #(
    parameter int unsigned WIN_LOG2 = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [12:0]              ref_in,
    input  logic [12:0]              dly_in,
    output logic                     busy,
    output logic                     valid,
    output logic [4:0]               tap
`ifdef DELAY_TAP_EST_ERR_OUT_EN
    ,
    output logic [14+WIN_LOG2-1:0]   err
`endif
);

    localparam int unsigned DW     = 13;
    localparam int unsigned NTAP   = 32;
    localparam int unsigned ACC_W  = 14 + WIN_LOG2;
    localparam int unsigned CNT_W  = (WIN_LOG2 > 5) ? WIN_LOG2 : 5;
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(NTAP - 1);
    localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'((1 << WIN_LOG2) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ACC,
        S_CMP,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [4:0]         k_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   best_err_q;
    logic [4:0]         best_k_q;
    logic               busy_q;
    logic               valid_q;
    logic [4:0]         tap_q;
`ifdef DELAY_TAP_EST_ERR_OUT_EN
    logic [ACC_W-1:0]   err_q;
`endif

    logic [DW-1:0]      hist_q [NTAP];
    logic [DW-1:0]      dly_r_q;

    logic signed [13:0] diff_c;
    logic [13:0]        abs_c;
    logic [ACC_W-1:0]   acc_d;

    // Reference history and aligned delayed sample; free-running, never reset.
    always_ff @(posedge clk) begin
        hist_q[0] <= ref_in;
        for (int j = 1; j < int'(NTAP); j++) begin
            hist_q[j] <= hist_q[j-1];
        end
        dly_r_q <= dly_in;
    end

    // 14-bit signed difference cannot overflow for 13-bit signed operands.
    always_comb begin
        diff_c = $signed({dly_r_q[DW-1], dly_r_q}) - $signed({hist_q[k_q][DW-1], hist_q[k_q]});
        abs_c  = diff_c[13] ? 14'(-diff_c) : 14'(diff_c);
        acc_d  = acc_q + ACC_W'(abs_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            best_err_q <= '1;
            best_k_q   <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            tap_q      <= '0;
`ifdef DELAY_TAP_EST_ERR_OUT_EN
            err_q      <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FILL;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                S_FILL: begin
                    if (cnt_q == FILL_LAST) begin
                        state_q    <= S_ACC;
                        cnt_q      <= '0;
                        k_q        <= '0;
                        acc_q      <= '0;
                        best_err_q <= '1;
                        best_k_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_ACC: begin
                    acc_q <= acc_d;
                    if (cnt_q == ACC_LAST) begin
                        state_q <= S_CMP;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_CMP: begin
                    // Strict compare so ties keep the smaller lag.
                    if (acc_q < best_err_q) begin
                        best_err_q <= acc_q;
                        best_k_q   <= k_q;
                    end
                    if (k_q == 5'd31) begin
                        state_q <= S_DONE;
                    end else begin
                        k_q     <= k_q + 5'd1;
                        acc_q   <= '0;
                        state_q <= S_ACC;
                    end
                end
                S_DONE: begin
                    tap_q   <= best_k_q;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
`ifdef DELAY_TAP_EST_ERR_OUT_EN
                    err_q   <= best_err_q;
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign tap   = tap_q;
`ifdef DELAY_TAP_EST_ERR_OUT_EN
    assign err   = err_q;
`endif

endmodule

// File: tb/tb_delay_tap_estimator.sv
// Directed bench for delay_tap_estimator: known delays, ties, reset abort and ignored start pulses.
module tb_delay_tap_estimator;

    localparam int unsigned W   = 6;
    localparam int          LAT = 1 + 32 + 32 * ((1 << W) + 1);

    logic        clk;
    logic        rst;
    logic        start;
    logic [12:0] ref_in;
    logic [12:0] dly_in;
    logic        busy;
    logic        valid;
    logic [4:0]  tap;
`ifdef DELAY_TAP_EST_ERR_OUT_EN
    logic [14+W-1:0] err;
`endif

    delay_tap_estimator #(.WIN_LOG2(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ref_in (ref_in),
        .dly_in (dly_in),
        .busy   (busy),
        .valid  (valid),
        .tap    (tap)
`ifdef DELAY_TAP_EST_ERR_OUT_EN
        ,
        .err    (err)
`endif
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          mode  = 0;
    int          dly   = 0;
    bit          alt_ph = 1'b0;
    logic [12:0] tb_hist [64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; new stimulus driven 1 ns after the edge. tb_hist[0] is the current ref sample.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 63; i > 0; i--) tb_hist[i] = tb_hist[i-1];
        case (mode)
            0: tb_hist[0] = 13'($urandom);
            1: tb_hist[0] = 13'd100;
            default: begin
                alt_ph = ~alt_ph;
                tb_hist[0] = alt_ph ? 13'h0FFF : 13'h1000;
            end
        endcase
        ref_in = tb_hist[0];
        dly_in = tb_hist[dly];
    endtask

    task automatic run_est(input logic [4:0] exp_tap, input bit poke, input string tag);
        int lat;
        int drops;
        int pulses;
        lat   = 0;
        drops = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy_after_start"}, 32'(busy), 32'd1);
        for (int n = 1; n <= LAT + 500; n++) begin
            if (poke && (n == 100 || n == LAT)) start = 1'b1;
            tick();
            start = 1'b0;
            if (valid) begin
                lat = n;
                break;
            end
            if (!busy) drops++;
        end
        check({tag, " latency"}, 32'(lat), 32'(LAT));
        check({tag, " busy_drops"}, 32'(drops), 32'd0);
        check({tag, " tap"}, 32'(tap), 32'(exp_tap));
        check({tag, " busy_with_valid"}, 32'(busy), 32'd0);
        tick();
        check({tag, " valid_one_cycle"}, 32'(valid), 32'd0);
        if (poke) begin
            pulses = 0;
            repeat (LAT + 200) begin
                tick();
                if (valid || busy) pulses++;
            end
            check({tag, " no_extra_run"}, 32'(pulses), 32'd0);
        end
    endtask

    initial begin
        int pulses;
        for (int i = 0; i < 64; i++) tb_hist[i] = '0;
        rst    = 1'b1;
        start  = 1'b0;
        ref_in = '0;
        dly_in = '0;
        repeat (3) tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset valid", 32'(valid), 32'd0);
        check("reset tap", 32'(tap), 32'd0);
`ifdef DELAY_TAP_EST_ERR_OUT_EN
        check("reset err", 32'(err), 32'd0);
`endif
        rst = 1'b0;
        repeat (2) tick();

        mode = 0; dly = 7;
        run_est(5'd7, 1'b0, "rand_d7");
`ifdef DELAY_TAP_EST_ERR_OUT_EN
        check("rand_d7 err", 32'(err), 32'd0);
`endif

        // Shift register tapped at s plus a registered output gives s+2 cycles of delay.
        mode = 0; dly = 20 + 2;
        run_est(5'd22, 1'b0, "shreg20");
        mode = 0; dly = 29 + 2;
        run_est(5'd31, 1'b0, "shreg29");

        mode = 1; dly = 0;
        run_est(5'd0, 1'b0, "const100");
`ifdef DELAY_TAP_EST_ERR_OUT_EN
        check("const100 err", 32'(err), 32'd0);
`endif

        mode = 2; dly = 3;
        run_est(5'd1, 1'b0, "alt_d3");

        // Abort mid-estimate; previous tap (1) must clear and no valid may appear.
        mode = 0; dly = 11;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (500) tick();
        rst = 1'b1;
        tick();
        check("abort busy", 32'(busy), 32'd0);
        check("abort tap", 32'(tap), 32'd0);
        check("abort valid", 32'(valid), 32'd0);
        rst = 1'b0;
        pulses = 0;
        repeat (LAT + 100) begin
            tick();
            if (valid) pulses++;
        end
        check("abort no_valid", 32'(pulses), 32'd0);
        run_est(5'd11, 1'b0, "after_abort");

        mode = 0; dly = 5;
        run_est(5'd5, 1'b1, "poke_busy_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/delay_tap_estimator.md
DELAY_TAP_ESTIMATOR -- requirements
Module: delay_tap_estimator

Interface
REQ-001 Parameter WIN_LOG2, default 6, meaning log2 of samples accumulated per candidate lag (legal 2..10).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  single-cycle request to begin an estimate.
REQ-005 ref_in  input  13  signed reference samples, one per clk.
REQ-006 dly_in  input  13  signed delayed copy of ref_in, one per clk.
REQ-007 busy  output  1  high while an estimate is in progress.
REQ-008 valid  output  1  one-cycle pulse when tap is updated.
REQ-009 tap  output  5  estimated lag in clk cycles, range 0..31.

Function
REQ-010 Every cycle: hist[0] <= ref_in, hist[j] <= hist[j-1] for j=1..31, dly_r <= dly_in; hist is 32 x 13 bits, shifts in all states.
REQ-011 Candidate lag k compares dly_r with hist[k]; dly_in equal to ref_in delayed D cycles (0<=D<=31) gives minimum error at k=D.
REQ-012 States: IDLE, FILL, ACC, CMP, DONE.
REQ-013 IDLE: start=1 -> FILL; start ignored in every other state.
REQ-014 FILL: 32 cycles priming hist, counter cleared; then ACC with k=0, acc=0, best_err=all ones, best_k=0.
REQ-015 ACC: acc += |dly_r - hist[k]| for exactly 2^WIN_LOG2 cycles, then CMP.
REQ-016 Difference computed at 14 bits signed; absolute value 14 bits unsigned (max 16383); acc width 14+WIN_LOG2, cannot overflow.
REQ-017 CMP (1 cycle): acc < best_err (strict) -> best_err=acc, best_k=k; ties keep smaller k; k=31 -> DONE, else k+1, acc=0, ACC.
REQ-018 DONE (1 cycle): tap <= best_k, valid=1, -> IDLE.
REQ-019 Latency start to valid: 1 + 32 + 32*(2^WIN_LOG2+1) cycles (2113 at default).
REQ-020 busy=1 in FILL, ACC, CMP, DONE; 0 in IDLE.
REQ-021 tap holds its last value between estimates; valid low except DONE cycle.
REQ-022 start coincident with the DONE cycle is ignored.

Reset
REQ-023 rst asserted: state=IDLE, busy=0, valid=0, tap=0, k=0, acc=0, best_err=all ones, best_k=0, counters=0.
REQ-024 hist and dly_r not reset.
REQ-025 rst mid-estimate aborts without a valid pulse; first start after release runs a full estimate including FILL.

Configuration
REQ-026 Macro DELAY_TAP_EST_ERR_OUT_EN defined: extra output err, width 14+WIN_LOG2, loaded with best_err in DONE, reset to 0, held otherwise.
REQ-027 Macro undefined: no err port and no err register; all other behaviour identical.

Verification
REQ-028 Drive dly_in = ref_in delayed 7 cycles, ref_in pseudo-random, start pulse -> valid after 2113 cycles, tap=7, busy falls with valid.
REQ-029 Drive dly_in through ShiftReg-equivalent delay (dout registered, tap setting 20) -> tap=22; tap setting 29 -> tap=31.
REQ-030 ref_in and dly_in constant 100 -> all lags tie at zero error, tap=0; err=0 with DELAY_TAP_EST_ERR_OUT_EN.
REQ-031 ref_in alternating +4095/-4096, dly_in = ref_in delayed 3 -> tap odd-consistent minimum at 1 (ties resolve to smallest k), no accumulator overflow.
REQ-032 Assert rst 500 cycles after start -> busy=0, tap=0, valid never pulses; next start completes normally with correct tap.
REQ-033 Pulse start while busy and in the DONE cycle -> ignored, exactly one valid pulse per accepted start.
